// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- register file with a per-register busy (scoreboard) bit.
//
// Holds 2**ADDR_W registers of DATA_W bits. Register 0 is hard-wired to zero
// and is never busy. Each register carries a busy bit:
//   * a reservation sets it (destination marked pending),
//   * a write clears it (result has arrived),
//   * flush clears all of them.
// wr_unrsv is a sticky flag. It records that a write landed on a non-zero
// register that had no outstanding reservation.
//
// Strobe semantics: wr_en, rsv_en and flush are single-cycle strobes sampled
// on the rising edge of clk. There is no back-pressure. Every strobe that is
// high at an edge (outside reset) takes effect at that edge.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, a read port whose address matches an in-flight write
//   (wr_en=1, wr_addr!=0) returns wr_data and busy=0 in the same cycle.
//   When undefined, reads return the stored value until the write's edge.
//
// Parameters:
//   DATA_W  register width in bits
//   ADDR_W  address width (depth = 2**ADDR_W)
//   NUM_RD  number of read ports (1..4)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   wr_en     in   write strobe
//   wr_addr   in   [ADDR_W]         write index
//   wr_data   in   [DATA_W]         write data
//   rd_addr   in   [NUM_RD*ADDR_W]  packed read indices, port k at k*ADDR_W
//   rd_data   out  [NUM_RD*DATA_W]  packed read data, port k at k*DATA_W
//   rd_busy   out  [NUM_RD]         busy bit of each addressed register
//   rsv_en    in   reservation strobe
//   rsv_addr  in   [ADDR_W]         index to reserve
//   flush     in   synchronous clear of all busy bits and wr_unrsv
//   wr_unrsv  out  sticky "write to unreserved register" flag
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       flush,
    output logic                       wr_unrsv
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              unrsv_q;
    logic              wr_hit;
    logic              rsv_hit;

    // Accesses to address 0 are dropped here, so entry 0 never changes
    // from its reset value of zero.
    assign wr_hit  = wr_en  && (wr_addr  != '0);
    assign rsv_hit = rsv_en && (rsv_addr != '0);

    // Register data. Flush does not touch data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The reservation is applied after the write clear. When both target the
    // same register in the same cycle, the register ends the cycle busy.
    always_comb begin
        busy_next = busy;
        if (wr_hit) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (rsv_hit) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Flush overrides any reservation made in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // The check uses the pre-edge busy bit. A write in a flush cycle still
    // updates data but never raises the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unrsv_q <= 1'b0;
        end else if (flush) begin
            unrsv_q <= 1'b0;
        end else if (wr_hit && !busy[wr_addr]) begin
            unrsv_q <= 1'b1;
        end
    end

    assign wr_unrsv = unrsv_q;

    // Combinational read ports.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data_k;
        logic              busy_k;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data_k = mem[ra];
            busy_k = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (ra == wr_addr)) begin
                data_k = wr_data;
                busy_k = 1'b0;
            end
`endif
            // Gating on rst also blocks a bypassed write during reset.
            if (rst || (ra == '0)) begin
                data_k = '0;
                busy_k = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_k;
        assign rd_busy[k]                  = busy_k;
    end

endmodule
